// File: rtl/commit_mon_pkg.sv
// Shared types and defaults for the commit-stream monitor.
// Fault decode lives here so the priority order is defined in one place.
package commit_mon_pkg;

  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_WDOG_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } mon_state_e;

  typedef enum logic [1:0] {
    ERR_NONE           = 2'd0,
    ERR_WDOG           = 2'd1,
    ERR_MISALIGN       = 2'd2,
    ERR_MISPRED_NOCTRL = 2'd3
  } mon_err_e;

  // Priority: misaligned > mispred-without-ctrl > watchdog.
  function automatic mon_err_e decode_fault(input logic       vld,
                                            input logic [1:0] pc_lo,
                                            input logic       mispred,
                                            input logic       ctrl,
                                            input logic       wdog_hit);
    if (vld && (pc_lo != 2'b00)) return ERR_MISALIGN;
    if (vld && mispred && !ctrl) return ERR_MISPRED_NOCTRL;
    if (wdog_hit)                return ERR_WDOG;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
  import commit_mon_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_count <= '0;
    end else if (i_clear) begin
      o_count <= '0;
    end else if (i_en && (o_count != '1)) begin
      o_count <= o_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/commit_monitor.sv
// Commit-trace monitor: run/halt/fault FSM, no-commit watchdog,
// saturating performance counters and fault PC capture.
module commit_monitor
  import commit_mon_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_insn_vld,
  input  logic             i_ctrl,
  input  logic             i_mispred,
  input  logic [31:0]      i_pc_commit,
  input  logic             i_halt,
  output logic [CNT_W-1:0] o_cycles,
  output logic [CNT_W-1:0] o_insns,
  output logic [CNT_W-1:0] o_ctrl_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt,
  output logic [31:0]      o_last_pc,
  output logic [1:0]       o_state,
  output logic             o_done,
  output logic             o_err,
  output logic [1:0]       o_err_code,
  output logic [31:0]      o_err_pc
);

  localparam int unsigned      WDOG_W    = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  mon_state_e        state_q, state_d;
  mon_err_e          err_q, fault;
  logic [WDOG_W-1:0] wdog_q;
  logic [31:0]       last_pc_q, err_pc_q;
  logic              active, wdog_hit, commit_ok, in_run;

  always_comb begin
    active    = (state_q == ST_IDLE) || (state_q == ST_RUN);
    in_run    = (state_q == ST_RUN);
    // Reaching WDOG_LAST on an idle cycle means this edge completes the window.
    wdog_hit  = active && !i_insn_vld && (wdog_q == WDOG_LAST);
    fault     = active ? decode_fault(i_insn_vld, i_pc_commit[1:0], i_mispred,
                                      i_ctrl, wdog_hit)
                       : ERR_NONE;
    commit_ok = active && i_insn_vld && (fault == ERR_NONE);
  end

  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fault != ERR_NONE) state_d = ST_FAULT;
          else if (i_halt)       state_d = ST_HALT;
          else if (commit_ok)    state_d = ST_RUN;
        end
        ST_RUN: begin
          if (fault != ERR_NONE) state_d = ST_FAULT;
          else if (i_halt)       state_d = ST_HALT;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wdog_q    <= '0;
      last_pc_q <= '0;
      err_q     <= ERR_NONE;
      err_pc_q  <= '0;
    end else if (i_clear) begin
      wdog_q    <= '0;
      last_pc_q <= '0;
      err_q     <= ERR_NONE;
      err_pc_q  <= '0;
    end else begin
      if (active && (fault == ERR_NONE)) begin
        wdog_q <= i_insn_vld ? '0 : wdog_q + WDOG_W'(1);
      end
      if (commit_ok) begin
        last_pc_q <= i_pc_commit;
      end
      if (fault != ERR_NONE) begin
        err_q    <= fault;
        err_pc_q <= (fault == ERR_WDOG) ? last_pc_q : i_pc_commit;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cycles (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear),
    .i_en(in_run), .o_count(o_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_insns (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear),
    .i_en(commit_ok), .o_count(o_insns)
  );

  sat_counter #(.WIDTH(CNT_W)) u_ctrl (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear),
    .i_en(commit_ok && i_ctrl), .o_count(o_ctrl_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_mispred (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear),
    .i_en(commit_ok && i_mispred), .o_count(o_mispred_cnt)
  );

  always_comb begin
    o_state    = state_q;
    o_done     = (state_q == ST_HALT);
    o_err      = (state_q == ST_FAULT);
    o_err_code = err_q;
    o_err_pc   = err_pc_q;
    o_last_pc  = last_pc_q;
  end

endmodule

// File: doc/commit_monitor.md
# commit_monitor

Synthesizable commit-stream monitor that sits directly downstream of the `pipelined` core's debug outputs. It consumes the per-cycle commit trace (`insn_vld`, `ctrl`, `mispred`, `pc_commit`, `halt`) and keeps saturating performance counters. It detects protocol faults and a no-commit watchdog, then exposes a sticky done/error status for the scoreboard and for on-board LEDs.

## Interface
- `CNT_W`, 32, width of every performance counter
- `WDOG_CYCLES`, 1024, consecutive no-commit cycles that trigger a watchdog fault (≥2)
- `i_clk`  in  1  clock, all state on rising edge
- `i_reset`  in  1  asynchronous, active-low reset
- `i_clear`  in  1  synchronous clear of counters, status and FSM
- `i_insn_vld`  in  1  an instruction commits this cycle
- `i_ctrl`  in  1  committing instruction is a branch/jump (qualified by `i_insn_vld`)
- `i_mispred`  in  1  committing control instruction was mispredicted (qualified by `i_insn_vld`)
- `i_pc_commit`  in  32  PC of committing instruction
- `i_halt`  in  1  core reports halt
- `o_cycles`  out  CNT_W  cycles spent in RUN
- `o_insns`  out  CNT_W  committed instructions
- `o_ctrl_cnt`  out  CNT_W  committed control instructions
- `o_mispred_cnt`  out  CNT_W  mispredictions
- `o_last_pc`  out  32  PC of most recent counted commit
- `o_state`  out  2  FSM state: IDLE=0, RUN=1, HALT=2, FAULT=3
- `o_done`  out  1  high while state is HALT
- `o_err`  out  1  high while state is FAULT
- `o_err_code`  out  2  0 none, 1 watchdog, 2 misaligned PC, 3 mispred without ctrl
- `o_err_pc`  out  32  PC captured at fault: offending commit PC, or `o_last_pc` for watchdog

## Operation
- **IDLE** → RUN on first valid, non-faulting commit. That commit is counted.
- **IDLE** → HALT on `i_halt`.
- **RUN** → HALT on `i_halt`. A valid commit in the same cycle is counted first.
- **IDLE** or **RUN** → FAULT on any fault.
- **HALT** and **FAULT** are absorbing. Only `i_clear` or reset leaves them, returning to IDLE.
- **Faults** (only sampled when `i_insn_vld`=1):
  - misaligned: `i_pc_commit[1:0]` != 0
  - mispred without ctrl: `i_mispred`=1 with `i_ctrl`=0
- **Fault priority:** misaligned > mispred-without-ctrl > watchdog.
- **Fault takes precedence over halt** in the same cycle.
- **Faulting commit:** not counted and does not update `o_last_pc`.
- **Watchdog counter:**
  - runs in IDLE and RUN, reset to 0 on every valid commit
  - reaching `WDOG_CYCLES` consecutive cycles without a commit → FAULT, code 1
- **Counters in RUN** (and on the IDLE→RUN commit):
  - `o_insns` +1 per valid commit
  - `o_ctrl_cnt` +1 if `i_ctrl`
  - `o_mispred_cnt` +1 if `i_mispred`
- **`o_cycles`:** +1 every cycle the registered state is RUN, including the cycle in which halt or fault is sampled.
- **Saturation:** all counters saturate at 2^CNT_W−1 and never wrap.
- **Freeze:** counters are frozen in HALT and FAULT.
- **`i_clear`:** wins over every simultaneous event. All counters, PCs, code and watchdog go to 0 and the state goes to IDLE.

## Timing
- **Reset:** every output is 0 (state IDLE, code 0) asynchronously while `i_reset`=0. Deassertion takes effect at the next edge.
- **Registered outputs:** all outputs are registered. An event sampled at edge N is visible after edge N.
- **Zero-latency decode:** status and counters update in the same edge as the sampled commit, with no added pipeline stage.
- **Watchdog fault timing:** with the last commit at edge N and no further commits, FAULT is visible after edge N+`WDOG_CYCLES`.
- **Async reset mid-run:** clears everything immediately, with no partial update.

## Structure
- Package `commit_mon_pkg` holds:
  - `mon_state_e` (IDLE/RUN/HALT/FAULT, 2-bit)
  - `mon_err_e` (NONE/WDOG/MISALIGN/MISPRED_NOCTRL, 2-bit)
  - default parameter constants
- Sub-module `sat_counter` is parameterized by width, with `i_clear`/`i_en` inputs and saturating increment. It is instantiated four times.
- The top holds the FSM, the watchdog counter, fault decode and priority, and the PC capture.

## Test plan
- **Normal run and halt:** 10 aligned commits at 0x0..0x24, 3 with ctrl and 1 with mispred, halt asserted with the 10th → state HALT, `o_insns`=10, `o_ctrl_cnt`=3, `o_mispred_cnt`=1, `o_last_pc`=0x24, `o_done`=1.
- **Misaligned PC:** commit PC 0x102 with `i_halt` also high → FAULT, code 2, `o_err_pc`=0x102, halt ignored, commit not counted.
- **Mispred without ctrl:** commit with `i_mispred`=1, `i_ctrl`=0 at PC 0x40 → FAULT, code 3, `o_mispred_cnt` unchanged.
- **Watchdog:** `WDOG_CYCLES`=8, one commit at 0x10, then idle → FAULT visible exactly 8 edges later, code 1, `o_err_pc`=0x10. A commit on the 7th idle cycle instead prevents the fault.
- **Saturation:** `CNT_W`=4, 20 commits → `o_insns`=15, no wrap.
- **Clear and reset:** `i_clear` coincident with a valid commit → all zero, IDLE. Async `i_reset` pulse mid-RUN → all outputs 0 immediately.
